tdm_mux8: RTL

TDM_MUX8 -- requirements
Module: tdm_mux8

---
 rtl/tdm_mux8_if.sv | 23 ++
 rtl/tdm_mux8.sv | 94 +++++++++
 2 files changed

// File: rtl/tdm_mux8_if.sv
// Frame-in / serial-out bundle for tdm_mux8.
// The frame source sits on the master side and the multiplexer on the slave side.
interface tdm_mux8_if #(
    parameter int unsigned WIDTH = 1
);
    logic [8*WIDTH-1:0] D;
    logic               IN_VALID;
    logic               IN_READY;
    logic [WIDTH-1:0]   O;
    logic [2:0]         S;
    logic               OE;
    logic               FRAME;

    modport master (
        output D, IN_VALID,
        input  IN_READY, O, S, OE, FRAME
    );

    modport slave (
        input  D, IN_VALID,
        output IN_READY, O, S, OE, FRAME
    );
endinterface

// File: rtl/tdm_mux8.sv
// Eight-channel time-division multiplexer: latches a frame and plays its channels
// out on O/S, holding each slot for HOLD cycles, with back-to-back frame chaining.
module tdm_mux8 #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned HOLD  = 1
) (
    input  logic       CLK,
    input  logic       RSTN,
    tdm_mux8_if.slave  bus
);
    localparam int unsigned     HW        = $clog2(HOLD + 1);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [8*WIDTH-1:0] frame_q, frame_d;
    logic [2:0]         s_q, s_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [WIDTH-1:0]   o_q, o_d;
    logic               oe_q, oe_d;
    logic               fr_q, fr_d;
    logic               slot_end;
    logic               ready;
    logic               accept;
    logic [2:0]         s_nxt;

    assign slot_end = (hold_q == HOLD_LAST);
    // Ready opens only in the last cycle of slot 7 so a new frame chains without a gap.
    assign ready    = (state_q == IDLE) || ((s_q == 3'd7) && slot_end);
    assign accept   = bus.IN_VALID && ready;
    assign s_nxt    = s_q + 3'd1;

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        s_d     = s_q;
        hold_d  = hold_q;
        o_d     = o_q;
        oe_d    = oe_q;
        fr_d    = fr_q;
        if (accept) begin
            state_d = SEND;
            frame_d = bus.D;
            s_d     = 3'd0;
            hold_d  = '0;
            o_d     = bus.D[WIDTH-1:0];
            oe_d    = 1'b1;
            fr_d    = 1'b1;
        end else if (state_q == SEND) begin
            fr_d = 1'b0;
            if (!slot_end) begin
                hold_d = hold_q + HW'(1);
            end else if (s_q == 3'd7) begin
                state_d = IDLE;
                s_d     = 3'd0;
                hold_d  = '0;
                o_d     = '0;
                oe_d    = 1'b0;
            end else begin
                s_d    = s_nxt;
                hold_d = '0;
                o_d    = frame_q[s_nxt*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            frame_q <= '0;
            s_q     <= '0;
            hold_q  <= '0;
            o_q     <= '0;
            oe_q    <= 1'b0;
            fr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            s_q     <= s_d;
            hold_q  <= hold_d;
            o_q     <= o_d;
            oe_q    <= oe_d;
            fr_q    <= fr_d;
        end
    end

    assign bus.IN_READY = ready;
    assign bus.O        = o_q;
    assign bus.S        = s_q;
    assign bus.OE       = oe_q;
    assign bus.FRAME    = fr_q;
endmodule
